// File: rtl/cache_pkg.sv
// Cache-side types: arbiter state encoding and requester identity.
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D0   = 2'd2,
    ARB_D1   = 2'd3
  } arb_state_t;

  typedef enum logic {
    I = 1'b0,
    D = 1'b1
  } requester_t;

endpackage

`default_nettype wire

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: memory word and RAM handshake state.
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
// Grant selection out of ARB_IDLE: dcache priority, optional alternation on ties.
`default_nettype none

module arb_pick
  import cache_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic       i_req,
  input  logic       d_req,
  input  requester_t last_grant,
  output arb_state_t next_state
);

  always_comb begin
    next_state = ARB_IDLE;
    if (d_req && i_req) begin
      next_state = (FAIR && (last_grant == D)) ? ARB_I : ARB_D0;
    end else if (d_req) begin
      next_state = ARB_D0;
    end else if (i_req) begin
      next_state = ARB_I;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between icache word reads and atomic two-word dcache blocks.
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
  import cache_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      dword_idx,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state_q, state_d;
  requester_t last_grant_q, last_grant_d;
  logic       req_we_q, req_we_d;

  arb_state_t pick_state;
  logic       d_req;
  logic       access;
  logic       blk_we;
  logic       unused_daddr_lsbs;

  assign d_req             = dREN | dWEN;
  assign access            = (ramstate == ACCESS);
  assign iload             = ramload;
  assign dload             = ramload;
  assign unused_daddr_lsbs = ^daddr[2:0];

  // Once the dcache drops its request the in-flight word keeps the latched direction.
  assign blk_we = d_req ? dWEN : req_we_q;

  arb_pick #(
    .FAIR (FAIR)
  ) u_arb_pick (
    .i_req      (iREN),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .next_state (pick_state)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_we_d     = req_we_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    dword_idx    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        state_d = pick_state;
        if (pick_state == ARB_D0) begin
          req_we_d = dWEN;
        end
      end

      ARB_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (access) begin
          iwait        = ~iREN;
          last_grant_d = I;
          state_d      = ARB_IDLE;
        end
      end

      ARB_D0: begin
        dword_idx = 1'b0;
        ramaddr   = {daddr[31:3], 3'b000};
        ramWEN    = blk_we;
        ramREN    = ~blk_we;
        ramstore  = dstore;
        if (access) begin
          dwait = ~d_req;
          if (d_req) begin
            state_d = ARB_D1;
          end else begin
            last_grant_d = D;
            state_d      = ARB_IDLE;
          end
        end
      end

      ARB_D1: begin
        dword_idx = 1'b1;
        ramaddr   = {daddr[31:3], 3'b100};
        ramWEN    = blk_we;
        ramREN    = ~blk_we;
        ramstore  = dstore;
        if (access) begin
          dwait        = ~d_req;
          last_grant_d = D;
          state_d      = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= I;
      req_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_we_q     <= req_we_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one fair instance and one strict-priority instance share stimulus.
`default_nettype none

module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;

  logic  iwait, dwait, dword_idx, ramREN, ramWEN;
  word_t iload, dload, ramaddr, ramstore;
  logic  sp_iwait, sp_dwait, sp_dword_idx, sp_ramREN, sp_ramWEN;
  word_t sp_iload, sp_dload, sp_ramaddr, sp_ramstore;

  int checks;
  int errors;

  logic [9:0] exp_iw1, exp_dw1, exp_dw0;

  mem_arbiter #(.FAIR(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .dword_idx(dword_idx),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  mem_arbiter #(.FAIR(1'b0)) dut_sp (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(sp_iwait), .iload(sp_iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(sp_dwait), .dload(sp_dload), .dword_idx(sp_dword_idx),
    .ramREN(sp_ramREN), .ramWEN(sp_ramWEN), .ramaddr(sp_ramaddr), .ramstore(sp_ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;
    nRST     = 1'b1;
    #1 nRST  = 1'b0;
    #2;
    check("rst_flags", {iwait, dwait, ramREN, ramWEN, dword_idx}, 32'b11000);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);

    // icache word with immediate ACCESS
    next_cycle;
    nRST = 1'b1;
    ramload = 32'h1234_5678;
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = ACCESS;
    #3 check("t1_idle_ramREN", ramREN, 32'd0);
    next_cycle; #3;
    check("t1_ramREN", ramREN, 32'd1);
    check("t1_ramaddr", ramaddr, 32'h40);
    check("t1_iwait", iwait, 32'd0);
    check("t1_iload", iload, 32'h1234_5678);
    next_cycle; iREN = 1'b0; #3;
    check("t1_back_idle", {iwait, ramREN}, 32'b10);

    // dcache block read with BUSY stretches on word 0
    next_cycle; dREN = 1'b1; daddr = 32'h0000_1004; ramstate = BUSY; #3;
    next_cycle; #3;
    check("t2_busy1_addr", ramaddr, 32'h1000);
    check("t2_busy1_flags", {ramREN, ramWEN, dwait, dword_idx}, 32'b1010);
    next_cycle; #3;
    check("t2_busy2_flags", {ramREN, ramWEN, dwait, dword_idx}, 32'b1010);
    next_cycle; ramstate = ACCESS; #3;
    check("t2_w0_addr", ramaddr, 32'h1000);
    check("t2_w0_flags", {ramREN, dwait, dword_idx}, 32'b100);
    check("t2_dload", dload, 32'h1234_5678);
    next_cycle; #3;
    check("t2_w1_addr", ramaddr, 32'h1004);
    check("t2_w1_flags", {ramREN, dwait, dword_idx}, 32'b101);
    next_cycle; dREN = 1'b0; #3;
    check("t2_idle", {ramREN, dwait}, 32'b01);

    // dcache block write
    next_cycle; dWEN = 1'b1; daddr = 32'h0000_2000; dstore = 32'hDEAD_BEEF; ramstate = ACCESS; #3;
    next_cycle; #3;
    check("t3_w0_addr", ramaddr, 32'h2000);
    check("t3_w0_store", ramstore, 32'hDEAD_BEEF);
    check("t3_w0_flags", {ramREN, ramWEN, dwait, dword_idx}, 32'b0100);
    next_cycle; dstore = 32'hCAFE_F00D; #3;
    check("t3_w1_addr", ramaddr, 32'h2004);
    check("t3_w1_store", ramstore, 32'hCAFE_F00D);
    check("t3_w1_flags", {ramREN, ramWEN, dwait, dword_idx}, 32'b0101);
    next_cycle; dWEN = 1'b0; #3;
    check("t3_idle_wen", ramWEN, 32'd0);

    // dcache write dropped in D0: direction held, no dwait pulse, block abandoned
    next_cycle; dWEN = 1'b1; daddr = 32'h0000_6000; ramstate = BUSY; #3;
    next_cycle; #3;
    check("drop_d0", {ramREN, ramWEN, dwait, dword_idx}, 32'b0110);
    next_cycle; dWEN = 1'b0; #3;
    check("drop_hold", {ramREN, ramWEN, dwait, dword_idx}, 32'b0110);
    next_cycle; ramstate = ACCESS; #3;
    check("drop_access", {ramREN, ramWEN, dwait, dword_idx}, 32'b0110);
    next_cycle; #3;
    check("drop_idle", {ramREN, ramWEN, dwait, dword_idx}, 32'b0010);

    // icache arrives during D0 and must wait for the whole block
    next_cycle; dREN = 1'b1; daddr = 32'h0000_3000; ramstate = BUSY; #3;
    next_cycle; iREN = 1'b1; iaddr = 32'h0000_0500; #3;
    check("t5_d0_busy_addr", ramaddr, 32'h3000);
    next_cycle; ramstate = ACCESS; #3;
    check("t5_d0_addr", ramaddr, 32'h3000);
    check("t5_d0_flags", {iwait, dwait, dword_idx}, 32'b100);
    next_cycle; ramstate = BUSY; #3;
    check("t5_d1_busy_addr", ramaddr, 32'h3004);
    check("t5_d1_busy_flags", {iwait, dwait, dword_idx}, 32'b111);
    next_cycle; ramstate = ACCESS; #3;
    check("t5_d1_addr", ramaddr, 32'h3004);
    check("t5_d1_flags", {iwait, dwait, dword_idx}, 32'b101);
    next_cycle; dREN = 1'b0; #3;
    check("t5_idle", {iwait, ramREN}, 32'b10);
    next_cycle; #3;
    check("t5_i_addr", ramaddr, 32'h500);
    check("t5_i_iwait", iwait, 32'd0);
    next_cycle; iREN = 1'b0; #3;

    // both held continuously: fair alternates D,I,D,I; strict serves D only
    exp_iw1 = 10'b0111101111;
    exp_dw1 = 10'b1100111001;
    exp_dw0 = 10'b1001001001;
    next_cycle; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h600; daddr = 32'h4000; ramstate = ACCESS;
    for (int c = 0; c < 10; c++) begin
      #3;
      check($sformatf("tie_c%0d", c), {iwait, dwait, sp_iwait, sp_dwait},
            {28'd0, exp_iw1[c], exp_dw1[c], 1'b1, exp_dw0[c]});
      next_cycle;
    end
    iREN = 1'b0; dREN = 1'b0;
    repeat (3) next_cycle;

    // asynchronous reset while in D1 with RAM busy
    dREN = 1'b1; daddr = 32'h5000; dstore = 32'h1111_2222; ramstate = ACCESS; #3;
    next_cycle; #3;
    next_cycle; ramstate = BUSY; #3;
    check("rst_mid_pre", {ramaddr[31:1], dword_idx}, 32'h5005);
    #1 nRST = 1'b0;
    #1;
    check("rst_mid_flags", {iwait, dwait, ramREN, ramWEN, dword_idx}, 32'b11000);
    check("rst_mid_addr", ramaddr, 32'h0);
    check("rst_mid_store", ramstore, 32'h0);
    next_cycle; nRST = 1'b1; iREN = 1'b1; iaddr = 32'h700; ramstate = ACCESS; #3;
    check("rst_rel_idle", ramREN, 32'd0);
    next_cycle; #3;
    check("rst_tie_flags", {iwait, dwait, dword_idx, sp_dwait}, 32'b1000);
    check("rst_tie_addr", ramaddr, 32'h5000);
    next_cycle; iREN = 1'b0; dREN = 1'b0;
    repeat (2) next_cycle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
